// File: rtl/alu_pkg.sv
// Shared ALU result-stage types: field widths, arithmetic opcodes and the queued entry layout.
package alu_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned OPC_W  = 4;

    localparam logic [OPC_W-1:0] OP_ADD = 4'b0100;
    localparam logic [OPC_W-1:0] OP_INC = 4'b0101;
    localparam logic [OPC_W-1:0] OP_SUB = 4'b0110;
    localparam logic [OPC_W-1:0] OP_DEC = 4'b0111;

    typedef struct packed {
        logic [OPC_W-1:0]  opcode;
        logic [DATA_W-1:0] result;
        logic              c;
        logic              v;
        logic              z;
        logic              n;
    } entry_t;

    localparam int unsigned ENTRY_W = $bits(entry_t);

    // Only add/inc/sub/dec produce meaningful carry and overflow flags.
    function automatic logic is_arith(input logic [OPC_W-1:0] op);
        return (op == OP_ADD) || (op == OP_INC) || (op == OP_SUB) || (op == OP_DEC);
    endfunction

endpackage

// File: rtl/alu_result_if.sv
// Upstream/downstream bundle of the ALU result stage; sticky signals exist only with ALU_RESULT_STICKY_EN.
interface alu_result_if #(
    parameter int unsigned DEPTH = 4
);
    import alu_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                 in_valid;
    logic                 in_ready;
    logic [OPC_W-1:0]     in_opcode;
    logic [DATA_W-1:0]    in_result;
    logic                 in_c;
    logic                 in_v;
    logic                 out_valid;
    logic                 out_ready;
    logic [OPC_W-1:0]     out_opcode;
    logic [DATA_W-1:0]    out_result;
    logic                 out_c;
    logic                 out_v;
    logic                 out_z;
    logic                 out_n;
    logic [CNT_W-1:0]     count;
`ifdef ALU_RESULT_STICKY_EN
    logic                 sticky_clr;
    logic                 sticky_c;
    logic                 sticky_v;

    modport master (
        output in_valid, in_opcode, in_result, in_c, in_v, out_ready, sticky_clr,
        input  in_ready, out_valid, out_opcode, out_result, out_c, out_v, out_z, out_n,
               count, sticky_c, sticky_v
    );
    modport slave (
        input  in_valid, in_opcode, in_result, in_c, in_v, out_ready, sticky_clr,
        output in_ready, out_valid, out_opcode, out_result, out_c, out_v, out_z, out_n,
               count, sticky_c, sticky_v
    );
`else
    modport master (
        output in_valid, in_opcode, in_result, in_c, in_v, out_ready,
        input  in_ready, out_valid, out_opcode, out_result, out_c, out_v, out_z, out_n, count
    );
    modport slave (
        input  in_valid, in_opcode, in_result, in_c, in_v, out_ready,
        output in_ready, out_valid, out_opcode, out_result, out_c, out_v, out_z, out_n, count
    );
`endif

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; read data is forced to zero while empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = cnt;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: contents are masked while empty.
    always_ff @(posedge clk) begin
        if (rst_n && do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result queue: tags results with Z/N, masks C/V for non-arithmetic opcodes and buffers them FIFO.
// Optional sticky carry/overflow flags are built when ALU_RESULT_STICKY_EN is defined.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_result_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    entry_t           in_entry;
    entry_t           head;
    logic [CNT_W-1:0] fifo_count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign push = bus.in_valid && !full;
    assign pop  = bus.out_ready && !empty;

    // Flags are derived once at push time and travel with the entry.
    always_comb begin
        in_entry        = '0;
        in_entry.opcode = bus.in_opcode;
        in_entry.result = bus.in_result;
        in_entry.c      = is_arith(bus.in_opcode) ? bus.in_c : 1'b0;
        in_entry.v      = is_arith(bus.in_opcode) ? bus.in_v : 1'b0;
        in_entry.z      = (bus.in_result == '0);
        in_entry.n      = bus.in_result[DATA_W-1];
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (in_entry),
        .rdata (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    assign bus.in_ready   = !full;
    assign bus.out_valid  = !empty;
    assign bus.count      = fifo_count;
    assign bus.out_opcode = head.opcode;
    assign bus.out_result = head.result;
    assign bus.out_c      = head.c;
    assign bus.out_v      = head.v;
    assign bus.out_z      = head.z;
    assign bus.out_n      = head.n;

`ifdef ALU_RESULT_STICKY_EN
    logic sticky_c_q;
    logic sticky_v_q;

    // A clear on the same edge as a flagged push leaves only the new flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_c_q <= 1'b0;
            sticky_v_q <= 1'b0;
        end else begin
            sticky_c_q <= (bus.sticky_clr ? 1'b0 : sticky_c_q) | (push & in_entry.c);
            sticky_v_q <= (bus.sticky_clr ? 1'b0 : sticky_v_q) | (push & in_entry.v);
        end
    end

    assign bus.sticky_c = sticky_c_q;
    assign bus.sticky_v = sticky_v_q;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: queue-based reference model plus directed literal checks.
module tb_alu_result_stage;
    import alu_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_result_if #(.DEPTH(DEPTH)) bus ();

    alu_result_stage #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    entry_t q[$];
    bit     m_sc = 1'b0;
    bit     m_sv = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain queue of entries, updated with the values present at each rising edge.
    always @(posedge clk) begin : model
        bit     do_push;
        bit     do_pop;
        bit     arith;
        entry_t e;
        if (!rst_n) begin
            q.delete();
            m_sc = 1'b0;
            m_sv = 1'b0;
        end else begin
            do_pop   = (q.size() != 0) && bus.out_ready;
            do_push  = bus.in_valid && (q.size() != DEPTH);
            arith    = (bus.in_opcode >= 4) && (bus.in_opcode <= 7);
            e.opcode = bus.in_opcode;
            e.result = bus.in_result;
            e.c      = arith ? bus.in_c : 1'b0;
            e.v      = arith ? bus.in_v : 1'b0;
            e.z      = (bus.in_result == 0);
            e.n      = (bus.in_result >= 8);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(e);
`ifdef ALU_RESULT_STICKY_EN
            if (bus.sticky_clr) begin
                m_sc = 1'b0;
                m_sv = 1'b0;
            end
            if (do_push) begin
                m_sc = m_sc | e.c;
                m_sv = m_sv | e.v;
            end
`endif
        end
    end

    // Compare process: all outputs against the model on every falling edge.
    always @(negedge clk) begin : compare
        entry_t h;
        if (chk_en) begin
            h = (q.size() != 0) ? q[0] : '0;
            check("m_count",     32'(bus.count),      32'(q.size()));
            check("m_in_ready",  32'(bus.in_ready),   32'(q.size() != DEPTH));
            check("m_out_valid", 32'(bus.out_valid),  32'(q.size() != 0));
            check("m_opcode",    32'(bus.out_opcode), 32'(h.opcode));
            check("m_result",    32'(bus.out_result), 32'(h.result));
            check("m_flags",     32'({bus.out_c, bus.out_v, bus.out_z, bus.out_n}),
                                 32'({h.c, h.v, h.z, h.n}));
`ifdef ALU_RESULT_STICKY_EN
            check("m_sticky",    32'({bus.sticky_c, bus.sticky_v}), 32'({m_sc, m_sv}));
`endif
        end
    end

    logic clr_drv;
`ifdef ALU_RESULT_STICKY_EN
    assign bus.sticky_clr = clr_drv;
`endif

    // Drive one cycle of inputs from a falling edge, return at the next falling edge.
    task automatic step(input bit v, input logic [3:0] opc, input logic [3:0] res,
                        input bit c, input bit ov, input bit ordy, input bit clr);
        bus.in_valid  = v;
        bus.in_opcode = opc;
        bus.in_result = res;
        bus.in_c      = c;
        bus.in_v      = ov;
        bus.out_ready = ordy;
        clr_drv       = clr;
        @(negedge clk);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_opcode = '0;
        bus.in_result = '0;
        bus.in_c      = 1'b0;
        bus.in_v      = 1'b0;
        bus.out_ready = 1'b0;
        clr_drv       = 1'b0;
        @(negedge clk);
        step(1, OP_ADD, 4'd5, 1, 1, 1, 0);
        step(1, OP_ADD, 4'd5, 1, 1, 1, 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", 32'(bus.out_result), 32'd0);

        // Zero result with carry from an add.
        step(1, 4'b0100, 4'b0000, 1, 0, 0, 0);
        check("add_valid", 32'(bus.out_valid), 32'd1);
        check("add_result", 32'(bus.out_result), 32'd0);
        check("add_c", 32'(bus.out_c), 32'd1);
        check("add_z", 32'(bus.out_z), 32'd1);
        check("add_n", 32'(bus.out_n), 32'd0);
        check("add_count", 32'(bus.count), 32'd1);
        step(0, 0, 0, 0, 0, 1, 0);

        // Non-arithmetic opcode masks carry and overflow.
        step(1, 4'b0010, 4'b1010, 1, 1, 0, 0);
        check("logic_cvzn", 32'({bus.out_c, bus.out_v, bus.out_z, bus.out_n}), 32'b0001);
        step(0, 0, 0, 0, 0, 1, 0);

        // Fill to DEPTH, overflow push ignored, then drain in order.
        for (int i = 1; i <= 4; i++) step(1, OP_ADD, 4'(i), 0, 0, 0, 0);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        check("full_count", 32'(bus.count), 32'd4);
        step(1, OP_ADD, 4'd5, 0, 0, 0, 0);
        check("full_hold", 32'(bus.count), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            check("drain_order", 32'(bus.out_result), 32'(i));
            step(0, 0, 0, 0, 0, 1, 0);
        end
        check("drain_count", 32'(bus.count), 32'd0);
        check("drain_result", 32'(bus.out_result), 32'd0);

        // Steady push+pop at occupancy 2 across pointer wrap.
        step(1, OP_SUB, 4'd6, 0, 0, 0, 0);
        step(1, OP_SUB, 4'd7, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            check("wrap_order", 32'(bus.out_result), 32'(6 + k));
            step(1, OP_SUB, 4'(8 + k), 0, 0, 1, 0);
            check("wrap_count", 32'(bus.count), 32'd2);
        end
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);

        // Reset mid-operation discards entries and the concurrent push.
        for (int i = 0; i < 3; i++) step(1, OP_INC, 4'(9 + i), 0, 0, 0, 0);
        check("pre_rst_count", 32'(bus.count), 32'd3);
        rst_n = 1'b0;
        step(1, OP_ADD, 4'd12, 1, 1, 1, 0);
        rst_n = 1'b1;
        check("mid_rst_count", 32'(bus.count), 32'd0);
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("mid_rst_nostore", 32'(bus.count), 32'd0);

`ifdef ALU_RESULT_STICKY_EN
        step(1, 4'b0110, 4'd3, 0, 1, 0, 0);
        check("sticky_set", 32'(bus.sticky_v), 32'd1);
        step(1, OP_ADD, 4'd1, 0, 0, 0, 0);
        check("sticky_keep", 32'(bus.sticky_v), 32'd1);
        step(1, OP_SUB, 4'd2, 0, 1, 0, 1);
        check("sticky_clr_push", 32'(bus.sticky_v), 32'd1);
        step(0, 0, 0, 0, 0, 1, 1);
        check("sticky_clr", 32'(bus.sticky_v), 32'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0);
`endif

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            step($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0);
        end
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 1, 0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
